// File: rtl/pc_ctrl.sv
// Program-counter controller: configurable PC/jump widths, absolute or relative jumps,
// a hardware return-address stack with sticky error flag, and a sticky done stop at HALT_PC.
module pc_ctrl #(
   parameter int              PC_W    = 10,
   parameter int              JMP_W   = 9,
   parameter int              DEPTH   = 4,
   parameter logic [PC_W-1:0] HALT_PC = {PC_W{1'b1}}
) (
   input  logic                         CLK,
   input  logic                         init,
   input  logic                         halt,
   input  logic                         branch_skip,
   input  logic                         jump_en,
   input  logic                         jump_rel,
   input  logic                         call_en,
   input  logic                         ret_en,
   input  logic                         branch_taken,
   input  logic [JMP_W-1:0]             jump_addr,
   output logic [PC_W-1:0]              PC,
   output logic                         read_jump,
   output logic                         done,
   output logic                         stack_err,
   output logic [$clog2(DEPTH+1)-1:0]   depth
);

   localparam int              DW        = $clog2(DEPTH + 1);
   localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0]   DEPTH_MAX = DW'(DEPTH);
   localparam logic [DW-1:0]   DEP_ONE   = DW'(1'b1);
   localparam logic [DW-1:0]   DEP_ZERO  = {DW{1'b0}};
   localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1'b1);
   localparam logic [PC_W-1:0] PC_TWO    = PC_W'(2'd2);

   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] pc_nxt_s;
   logic [PC_W-1:0] pc_inc_s;
   logic [PC_W-1:0] pc_skip_s;
   logic [PC_W-1:0] jmp_zext_s;
   logic [PC_W-1:0] jmp_sext_s;
   logic [PC_W-1:0] jmp_rel_s;
   logic [PC_W-1:0] stack_top_s;
   logic [PC_W-1:0] stack_r [DEPTH];
   logic [DW-1:0]   depth_r;
   logic [DW-1:0]   depth_nxt_s;
   logic [DW-1:0]   top_idx_s;
   logic            done_r;
   logic            done_nxt_s;
   logic            err_r;
   logic            err_nxt_s;
   logic            read_jump_r;
   logic            push_s;

   // The jump field is narrower than the PC only when JMP_W < PC_W; equal widths need no extension.
   generate
      if (PC_W > JMP_W) begin : g_ext
         assign jmp_zext_s = {{(PC_W - JMP_W){1'b0}}, jump_addr};
         assign jmp_sext_s = {{(PC_W - JMP_W){jump_addr[JMP_W-1]}}, jump_addr};
      end else begin : g_noext
         assign jmp_zext_s = jump_addr;
         assign jmp_sext_s = jump_addr;
      end
   endgenerate

   assign pc_inc_s    = pc_r + PC_ONE;
   assign pc_skip_s   = pc_r + PC_TWO;
   assign jmp_rel_s   = pc_r + jmp_sext_s;
   assign top_idx_s   = depth_r - DEP_ONE;
   assign stack_top_s = stack_r[top_idx_s[AW-1:0]];

   // Next-state selection: done freeze, end detection, then one prioritised action per edge.
   always_comb begin
      pc_nxt_s    = pc_r;
      depth_nxt_s = depth_r;
      done_nxt_s  = done_r;
      err_nxt_s   = err_r;
      push_s      = 1'b0;
      if (done_r) begin
         pc_nxt_s = pc_r;
      end else if (pc_r == HALT_PC) begin
         done_nxt_s = 1'b1;
      end else if (halt) begin
         pc_nxt_s = pc_r;
      end else if (branch_skip) begin
         pc_nxt_s = pc_skip_s;
      end else if (ret_en) begin
         if (depth_r != DEP_ZERO) begin
            pc_nxt_s    = stack_top_s;
            depth_nxt_s = top_idx_s;
         end else begin
            pc_nxt_s  = pc_inc_s;
            err_nxt_s = 1'b1;
         end
      end else if (call_en) begin
         pc_nxt_s = jmp_zext_s;
         if (depth_r < DEPTH_MAX) begin
            push_s      = 1'b1;
            depth_nxt_s = depth_r + DEP_ONE;
         end else begin
            err_nxt_s = 1'b1;
         end
      end else if (jump_en) begin
         if (jump_rel) begin
            pc_nxt_s = jmp_rel_s;
         end else begin
            pc_nxt_s = jmp_zext_s;
         end
      end else begin
         pc_nxt_s = pc_inc_s;
      end
   end

   // Control state registers, cleared asynchronously by init.
   always_ff @(posedge CLK or posedge init) begin
      if (init) begin
         pc_r        <= {PC_W{1'b0}};
         depth_r     <= DEP_ZERO;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         read_jump_r <= 1'b0;
      end else begin
         pc_r        <= pc_nxt_s;
         depth_r     <= depth_nxt_s;
         done_r      <= done_nxt_s;
         err_r       <= err_nxt_s;
         read_jump_r <= branch_taken;
      end
   end

   // Return-address storage; contents after init are don't-care, so no reset.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         stack_r[depth_r[AW-1:0]] <= pc_inc_s;
      end else begin
         stack_r[depth_r[AW-1:0]] <= stack_r[depth_r[AW-1:0]];
      end
   end

   assign PC        = pc_r;
   assign read_jump = read_jump_r;
   assign done      = done_r;
   assign stack_err = err_r;
   assign depth     = depth_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomised and directed bench for pc_ctrl: two instances (deep stack / shallow stack with
// early HALT_PC) share stimulus and are compared every cycle against a queue-style reference.
module tb_pc_ctrl;

   logic       CLK = 1'b0;
   logic       init, halt, branch_skip, jump_en, jump_rel, call_en, ret_en, branch_taken;
   logic [8:0] jump_addr;
   logic [9:0] pc_a, pc_b;
   logic       rj_a, rj_b, done_a, done_b, err_a, err_b;
   logic [2:0] depth_a;
   logic [1:0] depth_b;

   always #5 CLK = ~CLK;

   pc_ctrl #(.PC_W(10), .JMP_W(9), .DEPTH(4)) dut_a (
      .CLK(CLK), .init(init), .halt(halt), .branch_skip(branch_skip), .jump_en(jump_en),
      .jump_rel(jump_rel), .call_en(call_en), .ret_en(ret_en), .branch_taken(branch_taken),
      .jump_addr(jump_addr), .PC(pc_a), .read_jump(rj_a), .done(done_a),
      .stack_err(err_a), .depth(depth_a)
   );

   pc_ctrl #(.PC_W(10), .JMP_W(9), .DEPTH(2), .HALT_PC(10'd1000)) dut_b (
      .CLK(CLK), .init(init), .halt(halt), .branch_skip(branch_skip), .jump_en(jump_en),
      .jump_rel(jump_rel), .call_en(call_en), .ret_en(ret_en), .branch_taken(branch_taken),
      .jump_addr(jump_addr), .PC(pc_b), .read_jump(rj_b), .done(done_b),
      .stack_err(err_b), .depth(depth_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: index 0 models dut_a, index 1 models dut_b.
   int m_pc [2];
   int m_dep[2];
   int m_stk[2][4];
   int cap  [2] = '{4, 2};
   int hlt  [2] = '{1023, 1000};
   bit m_done[2];
   bit m_err [2];
   bit m_rj;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k]   = 0;
         m_dep[k]  = 0;
         m_done[k] = 1'b0;
         m_err[k]  = 1'b0;
      end
      m_rj = 1'b0;
   endtask

   task automatic model_step(input int k);
      int off;
      off = jump_addr[8] ? int'(jump_addr) - 512 : int'(jump_addr);
      if (m_done[k]) begin
         // frozen until init
      end else if (m_pc[k] == hlt[k]) begin
         m_done[k] = 1'b1;
      end else if (halt) begin
         // hold
      end else if (branch_skip) begin
         m_pc[k] = (m_pc[k] + 2) % 1024;
      end else if (ret_en) begin
         if (m_dep[k] > 0) begin
            m_dep[k] = m_dep[k] - 1;
            m_pc[k]  = m_stk[k][m_dep[k]];
         end else begin
            m_pc[k]  = (m_pc[k] + 1) % 1024;
            m_err[k] = 1'b1;
         end
      end else if (call_en) begin
         if (m_dep[k] < cap[k]) begin
            m_stk[k][m_dep[k]] = (m_pc[k] + 1) % 1024;
            m_dep[k] = m_dep[k] + 1;
         end else begin
            m_err[k] = 1'b1;
         end
         m_pc[k] = int'(jump_addr);
      end else if (jump_en) begin
         m_pc[k] = jump_rel ? (m_pc[k] + off + 1024) % 1024 : int'(jump_addr);
      end else begin
         m_pc[k] = (m_pc[k] + 1) % 1024;
      end
   endtask

   task automatic check_all();
      check_eq("pc_a",    32'(pc_a),    m_pc[0]);
      check_eq("done_a",  32'(done_a),  32'(m_done[0]));
      check_eq("err_a",   32'(err_a),   32'(m_err[0]));
      check_eq("depth_a", 32'(depth_a), m_dep[0]);
      check_eq("rj_a",    32'(rj_a),    32'(m_rj));
      check_eq("pc_b",    32'(pc_b),    m_pc[1]);
      check_eq("done_b",  32'(done_b),  32'(m_done[1]));
      check_eq("err_b",   32'(err_b),   32'(m_err[1]));
      check_eq("depth_b", 32'(depth_b), m_dep[1]);
      check_eq("rj_b",    32'(rj_b),    32'(m_rj));
   endtask

   task automatic cycle();
      branch_taken = 1'($urandom_range(0, 1));
      @(posedge CLK);
      if (init) begin
         model_reset();
      end else begin
         model_step(0);
         model_step(1);
         m_rj = branch_taken;
      end
      #1;
      check_all();
   endtask

   task automatic drive(input bit h, input bit s, input bit r, input bit c,
                        input bit j, input bit rel, input int addr);
      halt        = h;
      branch_skip = s;
      ret_en      = r;
      call_en     = c;
      jump_en     = j;
      jump_rel    = rel;
      jump_addr   = 9'(addr);
      cycle();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic pulse_init();
      init = 1'b1;
      #1;
      model_reset();
      check_all();
      init = 1'b0;
   endtask

   task automatic drive_random();
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 511)));
   endtask

   initial begin
      init = 1'b1; halt = 1'b0; branch_skip = 1'b0; jump_en = 1'b0; jump_rel = 1'b0;
      call_en = 1'b0; ret_en = 1'b0; branch_taken = 1'b0; jump_addr = 9'd0;
      model_reset();
      @(posedge CLK);
      #1;
      check_all();
      init = 1'b0;

      // reset and increment
      repeat (5) idle();
      check_eq("pc_is_5", 32'(pc_a), 5);
      pulse_init();
      check_eq("pc_async_clr", 32'(pc_a), 0);
      repeat (3) idle();
      check_eq("pc_is_3", 32'(pc_a), 3);

      // absolute and relative jumps
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100);
      check_eq("jmp_abs", 32'(pc_a), 100);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'h1FE);
      check_eq("jmp_rel_neg", 32'(pc_a), 18);

      // nested call/return and underflow
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 50);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80);
      check_eq("call_depth2", 32'(depth_a), 2);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_eq("ret_51", 32'(pc_a), 51);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_eq("ret_11", 32'(pc_a), 11);
      check_eq("ret_depth0", 32'(depth_a), 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_eq("underflow_pc", 32'(pc_a), 12);
      check_eq("underflow_err", 32'(err_a), 1);

      // priority
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 200);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 300);
      check_eq("halt_pc", 32'(pc_a), 200);
      check_eq("halt_depth", 32'(depth_a), 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
      check_eq("skip_over_jump", 32'(pc_a), 202);

      // overflow on the two-entry stack
      pulse_init();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 50);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 120);
      check_eq("ovf_pc", 32'(pc_b), 120);
      check_eq("ovf_depth", 32'(depth_b), 2);
      check_eq("ovf_err", 32'(err_b), 1);
      check_eq("deep_no_err", 32'(err_a), 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_eq("ovf_ret_51", 32'(pc_b), 51);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check_eq("ovf_ret_11", 32'(pc_b), 11);

      // wrap past 1023 on dut_b, end stop on dut_a
      pulse_init();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 511);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 255);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 255);
      idle();
      idle();
      check_eq("reach_1023", 32'(pc_a), 1023);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      check_eq("wrap_to_0", 32'(pc_b), 0);
      check_eq("done_rise", 32'(done_a), 1);
      check_eq("done_pc", 32'(pc_a), 1023);
      for (int i = 0; i < 10; i++) begin
         drive_random();
         check_eq("done_frozen", 32'(pc_a), 1023);
      end
      pulse_init();
      check_eq("done_cleared", 32'(done_a), 0);

      // end stop at a non-default HALT_PC
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 500);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 255);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 245);
      check_eq("reach_1000", 32'(pc_b), 1000);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7);
      check_eq("done_b_rise", 32'(done_b), 1);
      check_eq("done_b_pc", 32'(pc_b), 1000);
      check_eq("done_b_nopush", 32'(depth_b), 0);

      // randomised run against the reference
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_init();
         end
         drive_random();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter controller for the single-cycle processor, succeeding the fixed 10-bit PC. It adds configurable PC and jump-field widths, absolute or PC-relative jumps, a hardware return-address stack for call/return, a sticky stack-error flag, and an automatic `done` stop at a configurable end address. It sits between the instruction decoder/branch logic and the instruction ROM address input.

## Interface

Parameters:
- `PC_W`, 10, PC width in bits; `PC` wraps modulo 2**PC_W.
- `JMP_W`, 9, jump-field width; must satisfy JMP_W <= PC_W.
- `DEPTH`, 4, return-stack entries; minimum 1.
- `HALT_PC`, 2**PC_W-1, PC value at which the block stops and raises `done`.

Ports:
- `CLK`  in  1  clock, rising edge.
- `init`  in  1  reset, asynchronous, active-high.
- `halt`  in  1  hold PC this cycle.
- `branch_skip`  in  1  advance PC by 2.
- `jump_en`  in  1  load jump target.
- `jump_rel`  in  1  with `jump_en`: 1 = PC + sign-extended `jump_addr`; 0 = zero-extended `jump_addr`.
- `call_en`  in  1  push PC+1 and jump to zero-extended `jump_addr`.
- `ret_en`  in  1  pop the stack top into PC.
- `branch_taken`  in  1  branch outcome, registered to `read_jump`.
- `jump_addr`  in  JMP_W  jump target or offset.
- `PC`  out  PC_W  current instruction address.
- `read_jump`  out  1  `branch_taken` delayed one cycle.
- `done`  out  1  sticky end-of-program flag.
- `stack_err`  out  1  sticky overflow/underflow flag.
- `depth`  out  clog2(DEPTH+1)  occupied stack entries.

## Operation

- `init` high asynchronously forces `PC`=0, `read_jump`=0, `done`=0, `stack_err`=0, `depth`=0; stack contents are don't-care. This applies mid-operation, including while `done`=1.
- `read_jump` <= `branch_taken` on every rising edge with `init` low, including halt, done, and stack-error cycles.
- `done` state: if `done`=1, `PC`, the stack and `depth` hold until `init`.
- End detection: at an edge with `done`=0 and `PC`==`HALT_PC`, `done` <= 1 and `PC` holds. This check overrides all control inputs.
- Otherwise, one action per edge, in this priority: `halt` > `branch_skip` > `ret_en` > `call_en` > `jump_en` > increment.
  - halt: `PC` holds.
  - skip: `PC` <= PC+2.
  - ret: if `depth`>0, `PC` <= top and `depth`--. If `depth`==0, `PC` <= PC+1 and `stack_err` <= 1.
  - call: `PC` <= zero-extended `jump_addr`. If `depth`<DEPTH, push PC+1 and `depth`++. If full, nothing is pushed, `depth` holds, and `stack_err` <= 1.
  - jump: absolute or relative as selected by `jump_rel`.
  - increment: `PC` <= PC+1.
- All arithmetic is modulo 2**PC_W. A relative offset is sign-extended from JMP_W to PC_W. Pushed return addresses also wrap.
- Lower-priority inputs asserted in the same cycle are ignored with no side effects; for example, `ret_en` under `halt` does not pop.

## Timing

- Single-cycle: every `PC` update is visible one clock after the controlling inputs are sampled.
- `read_jump` latency is 1 cycle.
- `done` rises one edge after `PC` first equals `HALT_PC`; `PC` remains at `HALT_PC`.
- `stack_err` rises on the edge of the offending call or return. It stays high until `init`, and the block keeps operating.
- `depth` changes on the same edge as the push or pop.
- Reset assertion is asynchronous; deassertion is synchronous to `CLK` (synchronised externally). The first edge after release performs a normal update from `PC`=0.

## Test plan

- Reset/increment: pulse `init` mid-cycle with `PC`=5 -> `PC`=0 immediately. Then 3 idle edges -> `PC`=3, `read_jump` tracks `branch_taken` with 1-cycle lag.
- Jumps (defaults): at `PC`=20, `jump_en`=1, `jump_rel`=1, `jump_addr`=9'h1FE -> `PC`=18. At `PC`=3, `jump_rel`=0, `jump_addr`=100 -> `PC`=100. At `PC`=1023 relative +1 with `HALT_PC`=1000 -> `PC`=0.
- Stack: nested calls from `PC`=10 to 50, then from 50 to 80 -> `depth`=2. Return -> `PC`=51; return -> `PC`=11, `depth`=0. Further return -> `PC`=12, `stack_err`=1.
- Overflow: DEPTH=2, three nested calls -> third call jumps, `depth` stays 2, `stack_err`=1; two returns unwind the first two calls correctly.
- Priority: `halt`+`call_en`+`ret_en` together -> `PC`, `depth` unchanged. `branch_skip`+`jump_en` -> PC+2.
- End: run to `PC`=`HALT_PC` with `jump_en` asserted -> `done`=1 next edge, `PC` frozen for 10 cycles despite all inputs; `init` clears `done`.
